// File: rtl/lfsr_8_bit_checker.sv
// Receive-side checker for the 8-bit maze LFSR stream: self-synchronises to
// the incoming state words, declares lock after a run of correct predictions,
// then flags and counts deviating words with a saturating error counter.
module lfsr_8_bit_checker #(
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned LOSS_COUNT  = 3,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   clear_count,
  output logic                   locked,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] error_count
);

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CTR_W     = 4;
  localparam int unsigned CTR_INC_W = CTR_W + 1;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Successor of an LFSR state word: shift left, feedback into bit 0.
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  state_e                 state_q,    state_d;
  logic [DATA_W-1:0]      expected_q, expected_d;
  logic [CTR_W-1:0]       run_q,      run_d;
  logic [CTR_W-1:0]       miss_q,     miss_d;
  logic                   locked_q,   locked_d;
  logic                   error_q,    error_d;
  logic [COUNT_WIDTH-1:0] count_q,    count_d;
  logic                   count_inc;

  logic                   word_zero;
  logic                   word_hit;
  logic [CTR_INC_W-1:0]   run_inc;
  logic [CTR_INC_W-1:0]   miss_inc;
  logic                   run_done;
  logic                   miss_done;

  // Word classification and counter thresholds shared by both comb processes.
  assign word_zero = (in_data == '0);
  assign word_hit  = (in_data == expected_q);
  assign run_inc   = {1'b0, run_q} + CTR_INC_W'(1);
  assign miss_inc  = {1'b0, miss_q} + CTR_INC_W'(1);
  assign run_done  = (run_inc == CTR_INC_W'(LOCK_COUNT));
  assign miss_done = (miss_inc == CTR_INC_W'(LOSS_COUNT));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: acquisition, confirmation and loss of lock, valid words only.
  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (!word_zero) state_d = ST_CONFIRM;
        end
        ST_CONFIRM: begin
          if (word_hit) begin
            if (run_done) state_d = ST_LOCKED;
          end else if (word_zero) begin
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (!word_hit && miss_done) state_d = ST_SEARCH;
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // Datapath and flag updates; prediction free-runs once locked.
  always_comb begin
    expected_d = expected_q;
    run_d      = run_q;
    miss_d     = miss_q;
    error_d    = 1'b0;
    count_inc  = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (!word_zero) begin
            expected_d = lfsr_next(in_data);
            run_d      = CTR_W'(1);
          end
        end
        ST_CONFIRM: begin
          if (word_hit) begin
            expected_d = lfsr_next(in_data);
            run_d      = run_inc[CTR_W-1:0];
            if (run_done) miss_d = '0;
          end else if (!word_zero) begin
            expected_d = lfsr_next(in_data);
            run_d      = CTR_W'(1);
          end else begin
            run_d      = '0;
          end
        end
        ST_LOCKED: begin
          expected_d = lfsr_next(expected_q);
          if (word_hit) begin
            miss_d = '0;
          end else begin
            error_d   = 1'b1;
            count_inc = 1'b1;
            if (miss_done) begin
              run_d  = '0;
              miss_d = '0;
            end else begin
              miss_d = miss_inc[CTR_W-1:0];
            end
          end
        end
        default: begin
          expected_d = expected_q;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);

    // Clear beats a simultaneous increment; the counter sticks at all-ones.
    count_d = count_q;
    if (clear_count) begin
      count_d = '0;
    end else if (count_inc && (count_q != '1)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      expected_q <= '0;
      run_q      <= '0;
      miss_q     <= '0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      expected_q <= expected_d;
      run_q      <= run_d;
      miss_q     <= miss_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
      count_q    <= count_d;
    end
  end

  assign locked      = locked_q;
  assign error       = error_q;
  assign error_count = count_q;

endmodule
